tqvp_dlmiles_i2ctarget: RTL and testbench

- I2C target (slave) peripheral for the TinyQV peripheral bus; the responder end of the team's I2C master.
- Watches SCL/SDA on ui_in, decodes START/STOP, and matches a programmable 7-bit address.
- Receives write bytes into an RX holding register and transmits read bytes from a TX holding register.
- Flags events to the CPU through status bits and user_interrupt. No clock stretching.

---
 rtl/tqvp_dlmiles_i2ctarget_if.sv | 20 ++
 rtl/tqvp_dlmiles_i2ctarget.sv | 237 +++++++++++++++++++++++
 tb/tb_tqvp_dlmiles_i2ctarget.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_dlmiles_i2ctarget_if.sv
// TinyQV peripheral bus bundle for the I2C target: register access plus interrupt.
interface tqvp_dlmiles_i2ctarget_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/tqvp_dlmiles_i2ctarget.sv
// I2C target: START/STOP decode, 7-bit address match, RX/TX holding registers,
// status/IRQ registers on the TinyQV bus. SDA is only ever pulled low, never stretched.
module tqvp_dlmiles_i2ctarget #(
  parameter int SCL_IN_BIT = 2,
  parameter int SDA_IN_BIT = 3,
  parameter int SDA_OE_BIT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       ui_in,
  output logic [7:0]                       uo_out,
  tqvp_dlmiles_i2ctarget_if.slave          bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, ACK_TX} state_t;

  state_t     state_reg, state_next;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       rw_reg, rw_next;
  logic       busy_reg, busy_next;
  logic       scl_prev_reg, sda_prev_reg;

  logic [7:0] ctrl_reg, rxdata_reg, txdata_reg;
  logic [3:0] irq_en_reg;
  logic       rx_valid_reg, tx_empty_reg, stop_seen_reg, overrun_reg, underrun_reg;
  logic       irq_reg;

  logic       do_capture, do_reload, set_overrun, set_stop;
  logic [7:0] load_val;

  wire scl = ui_in[SCL_IN_BIT];
  wire sda = ui_in[SDA_IN_BIT];
  wire scl_rise  = scl & ~scl_prev_reg;
  wire scl_fall  = ~scl & scl_prev_reg;
  wire start_det = scl & scl_prev_reg & sda_prev_reg & ~sda;
  wire stop_det  = scl & scl_prev_reg & ~sda_prev_reg & sda;

  wire wr_en = (bus.data_write_n != 2'b11);
  wire rd_en = (bus.data_read_n != 2'b11);

  // An empty TX register still has to put something on the wire: all ones.
  assign load_val = tx_empty_reg ? 8'hFF : txdata_reg;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_shift_next = tx_shift_reg;
    sda_oe_next   = sda_oe_reg;
    rw_next       = rw_reg;
    busy_next     = busy_reg;
    do_capture    = 1'b0;
    do_reload     = 1'b0;
    set_overrun   = 1'b0;
    set_stop      = 1'b0;
    if (stop_det) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
      set_stop    = busy_reg;
    end else if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        ADDR, RX_BYTE: begin
          if (scl_rise) begin
            shift_next   = {shift_reg[6:0], sda};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = 4'd0;
            if (state_reg == ADDR) begin
              if (ctrl_reg[7] && shift_reg[7:1] == ctrl_reg[6:0]) begin
                rw_next     = shift_reg[0];
                busy_next   = 1'b1;
                sda_oe_next = 1'b1;
                state_next  = ACK_ADDR;
              end else begin
                busy_next  = 1'b0;
                state_next = IDLE;
              end
            end else if (!rx_valid_reg) begin
              do_capture  = 1'b1;
              sda_oe_next = 1'b1;
              state_next  = ACK_RX;
            end else begin
              set_overrun = 1'b1;
              busy_next   = 1'b0;
              state_next  = IDLE;
            end
          end
        end
        ACK_ADDR, ACK_RX: begin
          if (scl_fall) begin
            if (state_reg == ACK_ADDR && rw_reg) begin
              do_reload     = 1'b1;
              tx_shift_next = load_val;
              sda_oe_next   = ~load_val[7];
              state_next    = TX_BYTE;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = RX_BYTE;
            end
          end
        end
        TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              bit_cnt_next = 4'd0;
              sda_oe_next  = 1'b0;
              state_next   = ACK_TX;
            end else begin
              tx_shift_next = {tx_shift_reg[6:0], 1'b0};
              sda_oe_next   = ~tx_shift_reg[6];
            end
          end
        end
        ACK_TX: begin
          // bit_cnt doubles as "master acknowledged" between the 9th rise and fall.
          if (scl_rise) begin
            if (sda) begin
              busy_next  = 1'b0;
              state_next = IDLE;
            end else begin
              bit_cnt_next = 4'd1;
            end
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next  = 4'd0;
            do_reload     = 1'b1;
            tx_shift_next = load_val;
            sda_oe_next   = ~load_val[7];
            state_next    = TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'd0;
      tx_shift_reg  <= 8'd0;
      sda_oe_reg    <= 1'b0;
      rw_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      scl_prev_reg  <= 1'b0;
      sda_prev_reg  <= 1'b0;
      ctrl_reg      <= 8'd0;
      rxdata_reg    <= 8'd0;
      txdata_reg    <= 8'd0;
      irq_en_reg    <= 4'd0;
      rx_valid_reg  <= 1'b0;
      tx_empty_reg  <= 1'b1;
      stop_seen_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      underrun_reg  <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_shift_reg <= tx_shift_next;
      sda_oe_reg   <= sda_oe_next;
      rw_reg       <= rw_next;
      busy_reg     <= busy_next;
      scl_prev_reg <= scl;
      sda_prev_reg <= sda;

      // CPU side first; hardware events below override it in the same cycle.
      if (wr_en) begin
        case (bus.address)
          6'h00: ctrl_reg <= bus.data_in[7:0];
          6'h04: begin
            if (bus.data_in[4]) stop_seen_reg <= 1'b0;
            if (bus.data_in[5]) overrun_reg   <= 1'b0;
            if (bus.data_in[6]) underrun_reg  <= 1'b0;
          end
          6'h10: irq_en_reg <= bus.data_in[3:0];
          default: ;
        endcase
      end
      if (rd_en && bus.address == 6'h08) rx_valid_reg <= 1'b0;

      if (do_capture) begin
        rxdata_reg   <= shift_reg;
        rx_valid_reg <= 1'b1;
      end
      if (do_reload) begin
        tx_empty_reg <= 1'b1;
        if (tx_empty_reg) underrun_reg <= 1'b1;
      end
      if (wr_en && bus.address == 6'h0C) begin
        txdata_reg   <= bus.data_in[7:0];
        tx_empty_reg <= 1'b0;
      end
      if (set_overrun) overrun_reg   <= 1'b1;
      if (set_stop)    stop_seen_reg <= 1'b1;

      irq_reg <= (irq_en_reg[0] & rx_valid_reg)
               | (irq_en_reg[1] & tx_empty_reg & busy_reg & rw_reg)
               | (irq_en_reg[2] & stop_seen_reg)
               | (irq_en_reg[3] & (overrun_reg | underrun_reg));
    end
  end

  always_comb begin
    bus.data_out = 32'd0;
    case (bus.address)
      6'h00: bus.data_out = {24'd0, ctrl_reg};
      6'h04: bus.data_out = {25'd0, underrun_reg, overrun_reg, stop_seen_reg,
                             rw_reg, busy_reg, tx_empty_reg, rx_valid_reg};
      6'h08: bus.data_out = {24'd0, rxdata_reg};
      6'h10: bus.data_out = {28'd0, irq_en_reg};
      default: ;
    endcase
  end

  assign bus.data_ready     = 1'b1;
  assign bus.user_interrupt = irq_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_uo
    assign uo_out[gi] = (gi == SDA_OE_BIT) ? sda_oe_reg : 1'b0;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.data_in[31:8], ui_in};

endmodule

// File: tb/tb_tqvp_dlmiles_i2ctarget.sv
// Directed bench: bit-banged I2C master on ui_in plus CPU register accesses.
module tb_tqvp_dlmiles_i2ctarget;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       sda_line;
  int         n_checks = 0;
  int         n_fail = 0;
  int         nz_cnt = 0;

  tqvp_dlmiles_i2ctarget_if bus ();

  tqvp_dlmiles_i2ctarget dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~uo_out[3];
  assign ui_in    = {4'b0000, sda_line, scl_m, 2'b00};

  always @(negedge clk) if (uo_out != 8'd0) nz_cnt <= nz_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    bus.address = a; bus.data_in = d; bus.data_write_n = 2'b10;
    tick(1);
    bus.data_write_n = 2'b11;
    $display("cpu write [%02h] <= %h", a, d);
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
    bus.address = a; bus.data_read_n = 2'b10;
    #1 d = bus.data_out;
    tick(1);
    bus.data_read_n = 2'b11;
    $display("cpu read  [%02h] => %h", a, d);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = sda_line; scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_bits8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    put_bits8(v);
    get_bit(ack);
    $display("i2c write %02h ack=%0d", v, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(nack);
    $display("i2c read  %02h nack=%0d", v, nack);
  endtask

  initial begin
    logic [31:0] d;
    logic        ack;
    logic [7:0]  rb;
    int          nz0;
    logic [7:0]  data2;

    bus.address = 6'd0; bus.data_in = 32'd0;
    bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
    tick(4);
    check("reset_uo_out", {24'd0, uo_out}, 32'h0);
    check("reset_irq", {31'd0, bus.user_interrupt}, 32'h0);
    rst = 1'b0;
    tick(2);
    cpu_read(6'h04, d); check("reset_status", d, 32'h02);
    cpu_read(6'h00, d); check("reset_ctrl", d, 32'h00);
    check("data_ready", {31'd0, bus.data_ready}, 32'h1);

    // Write 0x5A to address 0x42; interrupt one cycle after capture.
    cpu_write(6'h00, 32'hC2);
    cpu_write(6'h10, 32'h01);
    i2c_start();
    write_byte(8'h84, ack); check("t1_addr_ack", {31'd0, ack}, 32'h0);
    data2 = 8'h5A;
    for (int i = 7; i >= 1; i--) put_bit(data2[i]);
    sda_m = data2[0]; tick(Q); scl_m = 1'b1; tick(Q); scl_m = 1'b0;
    tick(1);
    check("t1_ack_drive", {24'd0, uo_out}, 32'h08);
    check("t1_irq_before", {31'd0, bus.user_interrupt}, 32'h0);
    tick(1);
    check("t1_irq_after", {31'd0, bus.user_interrupt}, 32'h1);
    tick(Q - 2);
    get_bit(ack); check("t1_data_ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    cpu_read(6'h04, d); check("t1_status", d, 32'h13);
    cpu_read(6'h08, d); check("t1_rxdata", d, 32'h5A);
    cpu_read(6'h04, d); check("t1_status_rd", d, 32'h12);
    cpu_write(6'h04, 32'h10);
    cpu_read(6'h04, d); check("t1_status_w1c", d, 32'h02);
    tick(2);
    check("t1_irq_clear", {31'd0, bus.user_interrupt}, 32'h0);

    // Read 0xA5 with NACK.
    cpu_write(6'h0C, 32'hA5);
    cpu_read(6'h04, d); check("t2_status_loaded", d, 32'h00);
    i2c_start();
    write_byte(8'h85, ack); check("t2_addr_ack", {31'd0, ack}, 32'h0);
    cpu_read(6'h04, d); check("t2_status_busy", d, 32'h0E);
    read_byte(1'b1, rb); check("t2_read_byte", {24'd0, rb}, 32'hA5);
    check("t2_released", {24'd0, uo_out}, 32'h0);
    cpu_read(6'h04, d); check("t2_status_idle", d, 32'h0A);
    i2c_stop();
    cpu_read(6'h04, d); check("t2_status_stop", d, 32'h0A);

    // Wrong address: bus untouched.
    nz0 = nz_cnt;
    i2c_start();
    write_byte(8'h86, ack); check("t3_addr_nack", {31'd0, ack}, 32'h1);
    write_byte(8'h11, ack); check("t3_data_nack", {31'd0, ack}, 32'h1);
    i2c_stop();
    tick(1);
    check("t3_uo_quiet", nz_cnt - nz0, 32'h0);
    cpu_read(6'h04, d); check("t3_status", d, 32'h0A);

    // Overrun on second byte.
    i2c_start();
    write_byte(8'h84, ack); check("t4_addr_ack", {31'd0, ack}, 32'h0);
    write_byte(8'h33, ack); check("t4_b1_ack", {31'd0, ack}, 32'h0);
    write_byte(8'h44, ack); check("t4_b2_nack", {31'd0, ack}, 32'h1);
    i2c_stop();
    cpu_read(6'h04, d); check("t4_status", d, 32'h23);
    cpu_write(6'h04, 32'h20);
    cpu_read(6'h04, d); check("t4_status_w1c", d, 32'h03);
    cpu_read(6'h08, d); check("t4_rxdata", d, 32'h33);

    // Underrun, then repeated START with a write.
    i2c_start();
    write_byte(8'h85, ack); check("t5_addr_ack", {31'd0, ack}, 32'h0);
    read_byte(1'b1, rb); check("t5_read_ff", {24'd0, rb}, 32'hFF);
    cpu_read(6'h04, d); check("t5_status_under", d, 32'h4A);
    i2c_start();
    write_byte(8'h84, ack); check("t5_rs_addr_ack", {31'd0, ack}, 32'h0);
    write_byte(8'h77, ack); check("t5_rs_data_ack", {31'd0, ack}, 32'h0);
    i2c_stop();
    cpu_read(6'h04, d); check("t5_status", d, 32'h53);
    cpu_read(6'h08, d); check("t5_rxdata", d, 32'h77);

    // Reset in the middle of an address ACK.
    i2c_start();
    put_bits8(8'h84);
    check("t6_ack_drive", {24'd0, uo_out}, 32'h08);
    rst = 1'b1;
    tick(1);
    check("t6_uo_reset", {24'd0, uo_out}, 32'h0);
    rst = 1'b0;
    tick(1);
    cpu_read(6'h00, d); check("t6_ctrl", d, 32'h00);
    cpu_read(6'h04, d); check("t6_status", d, 32'h02);
    cpu_read(6'h08, d); check("t6_rxdata", d, 32'h00);
    cpu_read(6'h10, d); check("t6_irq_en", d, 32'h00);
    check("t6_irq", {31'd0, bus.user_interrupt}, 32'h0);
    i2c_stop();
    check("t6_uo_after", {24'd0, uo_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
